// File: rtl/video_stream_checker.sv
// ============================================================================
// Module      : video_stream_checker
// Description : AXI4-Stream video sink. Tracks pixel position, checks frame
//               and line framing against the configured geometry, counts
//               completed frames and reports a per-frame additive checksum.
//               Optional macro READY_THROTTLE_EN: tready follows an LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_stream_checker #(
  parameter int image_width = 640,
  parameter int image_heigh = 480
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic        clear_i,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o,
  output logic [31:0] checksum_o,
  output logic        err_sof_o,
  output logic        err_eol_early_o,
  output logic        err_eol_late_o
);

  localparam logic [15:0] X_LAST = 16'(image_width - 1);
  localparam logic [15:0] Y_LAST = 16'(image_heigh - 1);

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] sum;

  logic        accept;
  logic        drop;
  logic        take;
  logic [15:0] cur_x;
  logic [15:0] cur_y;
  logic [31:0] new_sum;
  logic        at_last_x;
  logic        line_end;
  logic        frame_end;
  logic        set_sof;
  logic        set_early;
  logic        set_late;

  // A tuser beat always restarts position and sum, whether it opens a frame
  // or resynchronises in the middle of one.
  always_comb begin
    accept    = s_axis_tvalid & s_axis_tready;
    drop      = accept & ~s_axis_tuser & (state == WAIT_SOF);
    take      = accept & ~drop;
    cur_x     = s_axis_tuser ? 16'd0 : x_o;
    cur_y     = s_axis_tuser ? 16'd0 : y_o;
    new_sum   = (s_axis_tuser ? 32'd0 : sum) + s_axis_tdata;
    at_last_x = (cur_x == X_LAST);
    line_end  = s_axis_tlast | at_last_x;
    frame_end = take & line_end & (cur_y == Y_LAST);
    set_sof   = drop | (accept & s_axis_tuser & (state == IN_FRAME));
    set_early = take & s_axis_tlast & (cur_x < X_LAST);
    set_late  = take & ~s_axis_tlast & at_last_x;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= WAIT_SOF;
      sum             <= 32'd0;
      x_o             <= 16'd0;
      y_o             <= 16'd0;
      frame_done_o    <= 1'b0;
      frame_count_o   <= 16'd0;
      checksum_o      <= 32'd0;
      err_sof_o       <= 1'b0;
      err_eol_early_o <= 1'b0;
      err_eol_late_o  <= 1'b0;
    end else begin
      frame_done_o    <= frame_end;
      // Sticky flags: a new error in the clearing cycle takes priority.
      err_sof_o       <= set_sof   | (err_sof_o       & ~clear_i);
      err_eol_early_o <= set_early | (err_eol_early_o & ~clear_i);
      err_eol_late_o  <= set_late  | (err_eol_late_o  & ~clear_i);

      if (take) begin
        if (frame_end) begin
          state         <= WAIT_SOF;
          sum           <= 32'd0;
          x_o           <= 16'd0;
          y_o           <= 16'd0;
          checksum_o    <= new_sum;
          frame_count_o <= frame_count_o + 16'd1;
        end else begin
          state <= IN_FRAME;
          sum   <= new_sum;
          if (line_end) begin
            x_o <= 16'd0;
            y_o <= cur_y + 16'd1;
          end else begin
            x_o <= cur_x + 16'd1;
            y_o <= cur_y;
          end
        end
      end
    end
  end

`ifdef READY_THROTTLE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr          <= 16'hACE1;
      s_axis_tready <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      s_axis_tready <= lfsr[0];
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_stream_checker.sv
// Directed bench for video_stream_checker with a 4x2 frame geometry.
`default_nettype none

module tb_video_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic        tuser;
  logic        clear;
  logic [15:0] x;
  logic [15:0] y;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [31:0] checksum;
  logic        err_sof;
  logic        err_early;
  logic        err_late;

  int checks   = 0;
  int failures = 0;

  video_stream_checker #(
    .image_width(4),
    .image_heigh(2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (tdata),
    .s_axis_tlast   (tlast),
    .s_axis_tuser   (tuser),
    .clear_i        (clear),
    .x_o            (x),
    .y_o            (y),
    .frame_done_o   (frame_done),
    .frame_count_o  (frame_count),
    .checksum_o     (checksum),
    .err_sof_o      (err_sof),
    .err_eol_early_o(err_early),
    .err_eol_late_o (err_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat and returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [31:0] d, input logic u, input logic l);
    int n;
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (tready) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout: tready=%0b required=1", tready);
        break;
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tuser = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tready, x, y, frame_done, frame_count, checksum, err_sof, err_early, err_late} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: tready=%0b x=%0d y=%0d done=%0b cnt=%0d cs=%0d errs=%0b%0b%0b required all 0",
               tready, x, y, frame_done, frame_count, checksum, err_sof, err_early, err_late);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_tready: got=%0b required=1", tready);
    end
  endtask

  task automatic test_clean_frame();
    for (int i = 1; i <= 8; i++) begin
      send(32'(i), i == 1, i == 4 || i == 8);
      if (i == 4) begin
        checks++;
        if (x !== 16'd0 || y !== 16'd1) begin
          failures++;
          $display("FAIL clean_line_end: x=%0d y=%0d required x=0 y=1", x, y);
        end
      end
      if (i == 2) begin
        checks++;
        if (x !== 16'd2 || y !== 16'd0 || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL clean_mid_line: x=%0d y=%0d done=%0b required x=2 y=0 done=0", x, y, frame_done);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd36 || frame_count !== 16'd1 || x !== 16'd0 || y !== 16'd0) begin
      failures++;
      $display("FAIL clean_frame_end: done=%0b cs=%0d cnt=%0d x=%0d y=%0d required 1 36 1 0 0",
               frame_done, checksum, frame_count, x, y);
    end
    checks++;
    if ({err_sof, err_early, err_late} !== 3'b000) begin
      failures++;
      $display("FAIL clean_no_errors: errs=%03b required 000", {err_sof, err_early, err_late});
    end
    idle_cycle();
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL clean_done_pulse: done=%0b required 0", frame_done);
    end
  endtask

  task automatic test_eol_early();
    for (int i = 1; i <= 7; i++) begin
      send(32'(i), i == 1, i == 3 || i == 7);
      if (i == 3) begin
        checks++;
        if (err_early !== 1'b1 || x !== 16'd0 || y !== 16'd1) begin
          failures++;
          $display("FAIL eol_early_flag: err=%0b x=%0d y=%0d required 1 0 1", err_early, x, y);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd28 || frame_count !== 16'd2 || err_late !== 1'b0) begin
      failures++;
      $display("FAIL eol_early_frame: done=%0b cs=%0d cnt=%0d late=%0b required 1 28 2 0",
               frame_done, checksum, frame_count, err_late);
    end
    do_clear();
    checks++;
    if (err_early !== 1'b0) begin
      failures++;
      $display("FAIL eol_early_clear: err=%0b required 0", err_early);
    end
  endtask

  task automatic test_eol_late();
    for (int i = 1; i <= 8; i++) begin
      send(32'(i), i == 1, i == 8);
      if (i == 4) begin
        checks++;
        if (err_late !== 1'b1 || y !== 16'd1 || x !== 16'd0 || err_early !== 1'b0) begin
          failures++;
          $display("FAIL eol_late_flag: late=%0b y=%0d x=%0d early=%0b required 1 1 0 0", err_late, y, x, err_early);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd36 || frame_count !== 16'd3) begin
      failures++;
      $display("FAIL eol_late_frame: done=%0b cs=%0d cnt=%0d required 1 36 3", frame_done, checksum, frame_count);
    end
    do_clear();
  endtask

  task automatic test_sof_drop();
    send(32'd7, 1'b0, 1'b0);
    send(32'd9, 1'b0, 1'b0);
    checks++;
    if (err_sof !== 1'b1 || x !== 16'd0 || y !== 16'd0 || frame_count !== 16'd3) begin
      failures++;
      $display("FAIL sof_drop: err=%0b x=%0d y=%0d cnt=%0d required 1 0 0 3", err_sof, x, y, frame_count);
    end
    for (int i = 0; i < 8; i++) send(32'(100 + i), i == 0, i == 3 || i == 7);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd828 || frame_count !== 16'd4) begin
      failures++;
      $display("FAIL sof_drop_frame: done=%0b cs=%0d cnt=%0d required 1 828 4", frame_done, checksum, frame_count);
    end
    do_clear();
    checks++;
    if (err_sof !== 1'b0) begin
      failures++;
      $display("FAIL sof_clear: err=%0b required 0", err_sof);
    end
    clear = 1'b1;
    send(32'd5, 1'b0, 1'b0);
    clear = 1'b0;
    checks++;
    if (err_sof !== 1'b1) begin
      failures++;
      $display("FAIL sof_set_beats_clear: err=%0b required 1", err_sof);
    end
    do_clear();
  endtask

  task automatic test_midframe_sof();
    for (int i = 1; i <= 5; i++) send(32'(i), i == 1, i == 4);
    send(32'd50, 1'b1, 1'b0);
    checks++;
    if (err_sof !== 1'b1 || x !== 16'd1 || y !== 16'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL midframe_resync: err=%0b x=%0d y=%0d done=%0b required 1 1 0 0", err_sof, x, y, frame_done);
    end
    for (int i = 51; i <= 57; i++) begin
      send(32'(i), 1'b0, i == 53 || i == 57);
      if (i == 56) begin
        checks++;
        if (frame_done !== 1'b0 || frame_count !== 16'd4) begin
          failures++;
          $display("FAIL midframe_early_done: done=%0b cnt=%0d required 0 4", frame_done, frame_count);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd428 || frame_count !== 16'd5 || err_early !== 1'b0 || err_late !== 1'b0) begin
      failures++;
      $display("FAIL midframe_frame: done=%0b cs=%0d cnt=%0d early=%0b late=%0b required 1 428 5 0 0",
               frame_done, checksum, frame_count, err_early, err_late);
    end
    do_clear();
  endtask

  task automatic test_reset_midframe();
    for (int i = 1; i <= 5; i++) send(32'(i), i == 1, i == 4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tready, x, y, frame_done, frame_count, checksum, err_sof, err_early, err_late} !== '0) begin
      failures++;
      $display("FAIL reset_async: tready=%0b x=%0d y=%0d cnt=%0d cs=%0d required all 0",
               tready, x, y, frame_count, checksum);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) send(32'(i), i == 1, i == 4 || i == 8);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd36 || frame_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_midframe_frame: done=%0b cs=%0d cnt=%0d required 1 36 1", frame_done, checksum, frame_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) send(32'(10 + i), i == 0, i == 3 || i == 7);
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd108 || frame_count !== 16'd2) begin
      failures++;
      $display("FAIL b2b_frame1: done=%0b cs=%0d cnt=%0d required 1 108 2", frame_done, checksum, frame_count);
    end
    for (int i = 0; i < 8; i++) begin
      send(32'(20 + i), i == 0, i == 3 || i == 7);
      if (i == 0) begin
        checks++;
        if (frame_done !== 1'b0 || x !== 16'd1 || checksum !== 32'd108) begin
          failures++;
          $display("FAIL b2b_first_beat: done=%0b x=%0d cs=%0d required 0 1 108", frame_done, x, checksum);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || checksum !== 32'd188 || frame_count !== 16'd3 ||
        {err_sof, err_early, err_late} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_frame2: done=%0b cs=%0d cnt=%0d errs=%03b required 1 188 3 000",
               frame_done, checksum, frame_count, {err_sof, err_early, err_late});
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_eol_early();
    test_eol_late();
    test_sof_drop();
    test_midframe_sof();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
